// File: rtl/fifo_rd_adapter.sv
// fifo_rd_adapter
// Turns a FIFO pop interface with one cycle of read latency into a
// valid/ready stream. A 2-entry in-order skid buffer absorbs the word that is
// already in flight when the downstream stalls.
//
// Optional feature (FIFO_RD_ADAPTER_CNT_EN):
//   defined   -> word_cnt counts completed stream transfers (wraps at 16 bits)
//   undefined -> word_cnt is tied to zero and no counter is built
//
// The reset is synchronous and active high, sampled on rd_clk.

module fifo_rd_adapter #(
  parameter int data_width = 8
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_rdata,
  input  logic                  fifo_valid,
  output logic                  fifo_rd,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           word_cnt,
  output logic                  err_unexpected
);

  // Skid buffer storage and bookkeeping
  logic [data_width-1:0] mem [2];
  logic                  head;
  logic                  tail;
  logic [1:0]            count;
  logic                  pending;   // fifo_rd was high last cycle, data arrives now

  logic                  pop;
  logic                  push;
  logic [2:0]            occupancy; // buffered words plus the one in flight

  // Buffered plus in-flight words; never more than 2, so a new pop request is
  // allowed only when a slot is free now or one is being freed this cycle.
  assign occupancy = {1'b0, count} + {2'b00, pending};
  assign out_valid = !rst && (count != 2'd0);
  assign out_data  = mem[head];
  assign pop       = out_valid && out_ready;
  assign push      = !rst && fifo_valid && pending;
  assign fifo_rd   = !rst && !fifo_empty && ((occupancy < 3'd2) || pop);

  // Pointer, occupancy, in-flight and error-flag state
  always_ff @(posedge rd_clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    if (rst) begin
      head           <= 1'b0;
      tail           <= 1'b0;
      count          <= 2'd0;
      pending        <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      pending <= fifo_rd;

      if (push) begin
        tail <= ~tail;
      end

      if (pop) begin
        head <= ~head;
      end

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      // A strobe nobody asked for is dropped and flagged until reset.
      if (fifo_valid && !pending) begin
        err_unexpected <= 1'b1;
      end
    end
  end

  // Data capture into the slot at the tail pointer
  always_ff @(posedge rd_clk) begin
    // NOTE: the data array is deliberately not reset; count/pointers decide
    // which entries are meaningful, so stale contents are never observed.
    if (push) begin
      mem[tail] <= fifo_rdata;
    end
  end

`ifdef FIFO_RD_ADAPTER_CNT_EN
  logic [15:0] xfer_cnt;

  // Completed-transfer counter, wraps naturally at 16 bits
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      xfer_cnt <= 16'h0000;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + 16'h0001;
    end
  end

  assign word_cnt = xfer_cnt;
`else
  assign word_cnt = 16'h0000;
`endif

endmodule
